alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_wb_pkg.sv | 49 ++++
 rtl/alu_writeback_wb_fifo2.sv | 93 +++++++++
 rtl/alu_writeback.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback path.
// Contents:
//   - NZCV bit positions, which also define the flag_mask bit layout.
//   - wb_entry_t, the buffered writeback entry, and its width constant.
//   - occ_state_e, the occupancy encoding of the two-entry writeback buffer.
//   - apsr_merge(), the masked flag update applied when an entry commits.
package alu_wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned NZCV_W = 4;

    // Bit positions inside an NZCV vector. flag_mask uses the same layout.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Common flag_mask encodings used by the decoder.
    localparam logic [NZCV_W-1:0] MASK_NONE = 4'b0000;
    localparam logic [NZCV_W-1:0] MASK_NZ   = 4'b1100;
    localparam logic [NZCV_W-1:0] MASK_ALL  = 4'b1111;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [NZCV_W-1:0] nzcv;
        logic [REG_AW-1:0] rd_addr;
        logic              rd_we;
        logic [NZCV_W-1:0] flag_mask;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // Flags selected by mask take the new value, the rest keep the old one.
    function automatic logic [NZCV_W-1:0] apsr_merge(
        input logic [NZCV_W-1:0] old_flags,
        input logic [NZCV_W-1:0] new_flags,
        input logic [NZCV_W-1:0] mask
    );
        return (old_flags & ~mask) | (new_flags & mask);
    endfunction

endpackage

// File: rtl/alu_writeback_wb_fifo2.sv
// wb_fifo2 -- two-entry in-order buffer with an EMPTY/ONE/TWO occupancy FSM.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, entry_i     producer offers an entry (accepted only when ready_o=1)
//   pop_i               consumer commits the head entry this cycle
//   flush_i             drop everything; overrides push and pop
//   ready_o             registered "not full"
//   head_valid_o/head_o oldest buffered entry
//   tail_valid_o/tail_o second (younger) entry, valid only when two are held
module wb_fifo2
    import alu_wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t entry_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output logic      ready_o,
    output logic      head_valid_o,
    output wb_entry_t head_o,
    output logic      tail_valid_o,
    output wb_entry_t tail_o
);

    occ_state_e state_q, state_d;
    logic       ready_q;
    wb_entry_t  head_q, tail_q;
    logic       push_acc, pop_acc;

    // Flush wins: neither accept nor commit happens on a flush edge.
    assign push_acc = push_i & ready_q & ~flush_i;
    assign pop_acc  = pop_i & (state_q != OCC_EMPTY) & ~flush_i;

    // State register. ready_q is precomputed from the next state so that
    // ready_o has no combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != OCC_TWO);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: if (push_acc) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (push_acc && !pop_acc)      state_d = OCC_TWO;
                    else if (pop_acc && !push_acc) state_d = OCC_EMPTY;
                end
                OCC_TWO:   if (pop_acc) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        ready_o      = ready_q;
        head_valid_o = (state_q != OCC_EMPTY);
        tail_valid_o = (state_q == OCC_TWO);
        head_o       = head_q;
        tail_o       = tail_q;
    end

    // Entry storage. The head slot only changes when the head commits or the
    // buffer was empty, so head fields stay stable across a stalled write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (!flush_i) begin
            case (state_q)
                OCC_EMPTY: if (push_acc) head_q <= entry_i;
                OCC_ONE: begin
                    if (push_acc && pop_acc) head_q <= entry_i;
                    else if (push_acc)       tail_q <= entry_i;
                end
                OCC_TWO:   if (pop_acc) head_q <= tail_q;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback -- buffers ALU results, writes them to the register file in
// order, updates the architectural NZCV flags on commit and forwards the
// youngest pending register result.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             execute-stage handshake (in_ready registered)
//   alu_result, alu_n/z/c/v         result and flags of the offered entry
//   rd_addr, rd_we, flag_mask       destination, write enable, flag update mask
//   flush                           discard all uncommitted entries
//   rf_we, rf_waddr, rf_wdata       register-file write request of the head
//   rf_ready                        register-file write port granted
//   apsr_nzcv                       architectural flags {N,Z,C,V}
//   fwd_valid, fwd_addr, fwd_data   bypass of youngest pending register write
module alu_writeback
    import alu_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              rd_we,
    input  logic [NZCV_W-1:0] flag_mask,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic [NZCV_W-1:0] apsr_nzcv,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    wb_entry_t         in_entry, head, tail;
    logic              head_valid, tail_valid;
    logic              commit;
    logic [NZCV_W-1:0] apsr_q, apsr_d;

    always_comb begin
        in_entry              = '0;
        in_entry.result       = alu_result;
        in_entry.nzcv[FLAG_N] = alu_n;
        in_entry.nzcv[FLAG_Z] = alu_z;
        in_entry.nzcv[FLAG_C] = alu_c;
        in_entry.nzcv[FLAG_V] = alu_v;
        in_entry.rd_addr      = rd_addr;
        in_entry.rd_we        = rd_we;
        in_entry.flag_mask    = flag_mask;
    end

    // Flag-only entries (compare/test) retire without waiting for the RF port.
    assign commit = head_valid & (~head.rd_we | rf_ready) & ~flush;

    wb_fifo2 u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (in_valid),
        .entry_i      (in_entry),
        .pop_i        (commit),
        .flush_i      (flush),
        .ready_o      (in_ready),
        .head_valid_o (head_valid),
        .head_o       (head),
        .tail_valid_o (tail_valid),
        .tail_o       (tail)
    );

    assign rf_we    = head_valid & head.rd_we;
    assign rf_waddr = head.rd_addr;
    assign rf_wdata = head.result;

    assign apsr_d = apsr_merge(apsr_q, head.nzcv, head.flag_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apsr_q <= '0;
        end else if (commit) begin
            apsr_q <= apsr_d;
        end
    end

    assign apsr_nzcv = apsr_q;

    // The tail is younger than the head, so it wins when both write a register.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
        if (tail_valid && tail.rd_we) begin
            fwd_valid = 1'b1;
            fwd_addr  = tail.rd_addr;
            fwd_data  = tail.result;
        end else if (head_valid && head.rd_we) begin
            fwd_valid = 1'b1;
            fwd_addr  = head.rd_addr;
            fwd_data  = head.result;
        end
    end

endmodule
